regfile_port_sequencer: RTL and testbench
=========================================

Name: regfile_port_sequencer

Overview:
- Time-multiplexes a single-ported Y86 register file (one address, one write enable, synchronous read) between decode-stage operand reads and writeback-stage result writes.
- Reads srcA/srcB and writes dstE/dstM, as produced by the source/destination selection logic, over a fixed multi-cycle schedule.
- Arbitrates between read and write requests.
- Sits between the SEQ control path and the register file array.

Parameters:
- DATA_W, 64, register data width
- ADDR_W, 4, register index width
- NONREG, 4'hF, index meaning "no register"; never accessed

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rd_valid  in  1  read request
- rd_ready  out  1  read request accepted this cycle when rd_valid && rd_ready
- srcA  in  ADDR_W  first source index, sampled at read accept
- srcB  in  ADDR_W  second source index, sampled at read accept
- valA  out  DATA_W  operand A result, held until next read completes
- valB  out  DATA_W  operand B result, held until next read completes
- rd_done  out  1  one-cycle pulse; valA/valB valid from this cycle
- wr_valid  in  1  write request
- wr_ready  out  1  write request accepted when wr_valid && wr_ready
- dstE  in  ADDR_W  E destination, sampled at write accept
- dstM  in  ADDR_W  M destination, sampled at write accept
- valE  in  DATA_W  E data, sampled at write accept
- valM  in  DATA_W  M data, sampled at write accept
- wr_done  out  1  one-cycle pulse; both writes committed
- busy  out  1  state != IDLE
- rf_addr  out  ADDR_W  register file address
- rf_we  out  1  register file write enable
- rf_wdata  out  DATA_W  register file write data
- rf_rdata  in  DATA_W  register file read data; returns data for the address presented the previous cycle

Behaviour:
- States: IDLE, RD_A, RD_B, RD_CAP, WR_E, WR_M.
- Reset values:
  - state=IDLE
  - valA=valB=0
  - rd_done=wr_done=0
  - rf_we=0, rf_addr=NONREG, rf_wdata=0
  - all latched request fields cleared
- Ready rules:
  - wr_ready = (state==IDLE).
  - rd_ready = (state==IDLE) && !wr_valid.
  - Writes have priority over reads (the writer is the older instruction).
  - No request is ever accepted outside IDLE.
- Read schedule, accept at cycle T:
  - T+1 RD_A: rf_addr=srcA_q.
  - T+2 RD_B: rf_addr=srcB_q; valA <= (srcA_q==NONREG) ? 0 : rf_rdata.
  - T+3 RD_CAP: valB <= (srcB_q==NONREG) ? 0 : rf_rdata.
  - T+4: state=IDLE and rd_done=1.
  - Latency from accept to rd_done is exactly 4 cycles.
  - A new request may be accepted in the rd_done cycle.
- Write schedule, accept at cycle T:
  - T+1 WR_E: rf_addr=dstE_q, rf_wdata=valE_q, rf_we=1 iff dstE_q!=NONREG && dstE_q!=dstM_q.
  - T+2 WR_M: rf_addr=dstM_q, rf_wdata=valM_q, rf_we=1 iff dstM_q!=NONREG.
  - T+3: state=IDLE and wr_done=1.
- Collision rule: dstE==dstM (not NONREG) writes only valM, so M wins.
- Write-port gating:
  - rf_we=0 in every state except WR_E and WR_M.
  - Outside the write states, rf_addr/rf_wdata are don't-care, but rf_addr is driven NONREG when IDLE.
- Output holding:
  - valA/valB change only in RD_B/RD_CAP.
  - Requests arriving while busy are ignored (not queued); the requester holds valid until it sees ready.
- Inputs are sampled only at accept; changes afterwards have no effect.
- Reset asserted mid-transaction:
  - next cycle is IDLE with all reset values;
  - no rd_done or wr_done is emitted;
  - a partially completed write, e.g. WR_E done, stays committed.
- Fixed latency: cycle counts do not depend on NONREG skips; skipped accesses still occupy their cycle.

Test Plan:
- Reset; preload r3=0x11, r5=0x22. Read srcA=3, srcB=5 accepted at T -> rf_addr 3 at T+1, 5 at T+2; rd_done at T+4 with valA=0x11, valB=0x22.
- Read srcA=NONREG, srcB=4 (r4=0x99) -> valA=0, valB=0x99, rd_done at T+4. Repeat with srcA=4, srcB=NONREG -> valA=0x99, valB=0.
- Write dstE=2 valE=0xAA, dstM=7 valM=0xBB -> rf_we high at T+1 (addr 2) and T+2 (addr 7), wr_done at T+3. A readback of r2, r7 gives 0xAA, 0xBB.
- Write dstE=dstM=6, valE=1, valM=2 -> rf_we low at T+1, high at T+2; a later read of r6 gives 2. Write dstE=dstM=NONREG -> rf_we never asserts, wr_done still at T+3.
- rd_valid and wr_valid both high in IDLE -> wr_ready=1, rd_ready=0; write runs first. Read is accepted in the wr_done cycle and returns post-write values.
- rst pulsed at T+2 of a read -> IDLE next cycle, no rd_done, valA=valB=0. rst pulsed during WR_M -> rf_we=0 after the reset edge, no wr_done.

Source files
------------

// File: rtl/regfile_port_sequencer.sv
// Sequences decode reads (srcA, srcB) and writeback writes (dstE, dstM) onto a
// single-ported, synchronous-read register file with fixed latency.
module regfile_port_sequencer #(
    parameter int              DATA_W = 64,
    parameter int              ADDR_W = 4,
    parameter logic [ADDR_W-1:0] NONREG = 4'hF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] srcA,
    input  logic [ADDR_W-1:0] srcB,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    output logic              rd_done,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] dstE,
    input  logic [ADDR_W-1:0] dstM,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valM,
    output logic              wr_done,
    output logic              busy,
    output logic [ADDR_W-1:0] rf_addr,
    output logic              rf_we,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        RD_CAP,
        WR_E,
        WR_M
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] srcA_q;
    logic [ADDR_W-1:0] srcB_q;
    logic [ADDR_W-1:0] dstM_q;
    logic [DATA_W-1:0] valM_q;

    // Writes win arbitration: the writer is the older instruction.
    assign wr_ready = (state == IDLE);
    assign rd_ready = (state == IDLE) && !wr_valid;
    assign busy     = (state != IDLE);

    // NOTE: every register here uses non-blocking assignment, so all branches
    // see the pre-edge values of state and the latched request fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            srcA_q   <= '0;
            srcB_q   <= '0;
            dstM_q   <= '0;
            valM_q   <= '0;
            valA     <= '0;
            valB     <= '0;
            rd_done  <= 1'b0;
            wr_done  <= 1'b0;
            rf_addr  <= NONREG;
            rf_we    <= 1'b0;
            rf_wdata <= '0;
        end else begin
            rd_done <= 1'b0;
            wr_done <= 1'b0;
            case (state)
                IDLE: begin
                    // The E write is issued straight from the accepted inputs,
                    // so only the M half of the request needs holding.
                    if (wr_valid) begin
                        dstM_q   <= dstM;
                        valM_q   <= valM;
                        rf_addr  <= dstE;
                        rf_wdata <= valE;
                        rf_we    <= (dstE != NONREG) && (dstE != dstM);
                        state    <= WR_E;
                    end else if (rd_valid) begin
                        srcA_q  <= srcA;
                        srcB_q  <= srcB;
                        rf_addr <= srcA;
                        state   <= RD_A;
                    end
                end
                RD_A: begin
                    rf_addr <= srcB_q;
                    state   <= RD_B;
                end
                RD_B: begin
                    valA    <= (srcA_q == NONREG) ? '0 : rf_rdata;
                    rf_addr <= NONREG;
                    state   <= RD_CAP;
                end
                RD_CAP: begin
                    valB    <= (srcB_q == NONREG) ? '0 : rf_rdata;
                    rd_done <= 1'b1;
                    state   <= IDLE;
                end
                WR_E: begin
                    rf_addr  <= dstM_q;
                    rf_wdata <= valM_q;
                    rf_we    <= (dstM_q != NONREG);
                    state    <= WR_M;
                end
                WR_M: begin
                    rf_we   <= 1'b0;
                    rf_addr <= NONREG;
                    wr_done <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    rf_we   <= 1'b0;
                    rf_addr <= NONREG;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_port_sequencer.sv
// Self-checking bench: a transaction-level model predicts every cycle's outputs
// from accept times; directed scenarios add literal expectations on top.
module tb_regfile_port_sequencer;
    localparam int          DATA_W = 64;
    localparam int          ADDR_W = 4;
    localparam logic [3:0]  NONREG = 4'hF;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rd_valid = 1'b0, wr_valid = 1'b0;
    logic              rd_ready, wr_ready, rd_done, wr_done, busy, rf_we;
    logic [ADDR_W-1:0] srcA = '0, srcB = '0, dstE = '0, dstM = '0, rf_addr;
    logic [DATA_W-1:0] valE = '0, valM = '0, valA, valB, rf_wdata, rf_rdata;

    always #5 clk = ~clk;

    regfile_port_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NONREG(NONREG)) dut (
        .clk(clk), .rst(rst),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .srcA(srcA), .srcB(srcB),
        .valA(valA), .valB(valB), .rd_done(rd_done),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .dstE(dstE), .dstM(dstM),
        .valE(valE), .valM(valM), .wr_done(wr_done), .busy(busy),
        .rf_addr(rf_addr), .rf_we(rf_we), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
    );

    // Register file array: synchronous read of the previous cycle's address.
    logic [DATA_W-1:0] mem [16];
    logic [DATA_W-1:0] init_regs [16];
    logic              preload = 1'b1;
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_regs[i];
        end else if (rf_we) begin
            mem[rf_addr] <= rf_wdata;
        end
        rf_rdata <= mem[rf_addr];
    end

    // Reference model state
    logic [DATA_W-1:0] reg_model [16];
    int                cyc, free_at, rd_done_at, wr_done_at, pa_cyc, pb_cyc;
    logic [DATA_W-1:0] pa_val, pb_val, exp_valA, exp_valB;
    logic [3:0]        rd_addr_at [int];
    logic [3:0]        we_addr_at [int];
    logic [DATA_W-1:0] we_data_at [int];
    int                last_acc_kind;
    int                errors = 0, checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // Compare this cycle's outputs with the model, then advance the model.
    task automatic model_cycle();
        bit idle;
        idle = (cyc >= free_at);
        if (cyc == pa_cyc) exp_valA = pa_val;
        if (cyc == pb_cyc) exp_valB = pb_val;
        check("busy", 64'(busy), 64'(!idle));
        check("wr_ready", 64'(wr_ready), 64'(idle));
        check("rd_ready", 64'(rd_ready), 64'(idle && !wr_valid));
        check("rd_done", 64'(rd_done), 64'(cyc == rd_done_at));
        check("wr_done", 64'(wr_done), 64'(cyc == wr_done_at));
        check("valA", valA, exp_valA);
        check("valB", valB, exp_valB);
        if (we_addr_at.exists(cyc)) begin
            check("rf_we", 64'(rf_we), 64'd1);
            check("wr_addr", 64'(rf_addr), 64'(we_addr_at[cyc]));
            check("wr_data", rf_wdata, we_data_at[cyc]);
            reg_model[we_addr_at[cyc]] = we_data_at[cyc];
        end else begin
            check("rf_we", 64'(rf_we), 64'd0);
        end
        if (rd_addr_at.exists(cyc)) check("rd_addr", 64'(rf_addr), 64'(rd_addr_at[cyc]));
        else if (idle) check("idle_addr", 64'(rf_addr), 64'(NONREG));

        last_acc_kind = 0;
        if (rst) begin
            for (int k = cyc + 1; k <= cyc + 4; k++) begin
                rd_addr_at.delete(k);
                we_addr_at.delete(k);
                we_data_at.delete(k);
            end
            free_at = cyc + 1;
            rd_done_at = -1;
            wr_done_at = -1;
            pa_cyc = cyc + 1; pa_val = '0;
            pb_cyc = cyc + 1; pb_val = '0;
        end else if (idle && wr_valid) begin
            if (dstE != NONREG && dstE != dstM) begin
                we_addr_at[cyc + 1] = dstE;
                we_data_at[cyc + 1] = valE;
            end
            if (dstM != NONREG) begin
                we_addr_at[cyc + 2] = dstM;
                we_data_at[cyc + 2] = valM;
            end
            wr_done_at = cyc + 3;
            free_at = cyc + 3;
            last_acc_kind = 2;
        end else if (idle && rd_valid) begin
            rd_addr_at[cyc + 1] = srcA;
            rd_addr_at[cyc + 2] = srcB;
            pa_cyc = cyc + 3; pa_val = (srcA == NONREG) ? '0 : reg_model[srcA];
            pb_cyc = cyc + 4; pb_val = (srcB == NONREG) ? '0 : reg_model[srcB];
            rd_done_at = cyc + 4;
            free_at = cyc + 4;
            last_acc_kind = 1;
        end
    endtask

    task automatic step();
        #1;
        model_cycle();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic wait_accept(input int kind);
        for (int i = 0; i < 20; i++) begin
            step();
            if (last_acc_kind == kind) return;
        end
        check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic scramble_inputs();
        srcA = 4'($urandom); srcB = 4'($urandom);
        dstE = 4'($urandom); dstM = 4'($urandom);
        valE = {$urandom, $urandom}; valM = {$urandom, $urandom};
    endtask

    task automatic read_tx(input logic [3:0] a, input logic [3:0] b,
                           input logic [63:0] ea, input logic [63:0] eb);
        rd_valid = 1'b1; srcA = a; srcB = b;
        wait_accept(1);
        rd_valid = 1'b0;
        scramble_inputs();
        check("t1_addr_a", 64'(rf_addr), 64'(a));
        step();
        check("t2_addr_b", 64'(rf_addr), 64'(b));
        step();
        step();
        check("t4_rd_done", 64'(rd_done), 64'd1);
        check("t4_valA", valA, ea);
        check("t4_valB", valB, eb);
    endtask

    task automatic wr_tx(input logic [3:0] e, input logic [3:0] m,
                         input logic [63:0] ve, input logic [63:0] vm,
                         input logic we1, input logic we2);
        wr_valid = 1'b1; dstE = e; dstM = m; valE = ve; valM = vm;
        wait_accept(2);
        wr_valid = 1'b0;
        scramble_inputs();
        check("t1_we", 64'(rf_we), 64'(we1));
        step();
        check("t2_we", 64'(rf_we), 64'(we2));
        step();
        check("t3_wr_done", 64'(wr_done), 64'd1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) init_regs[i] = {$urandom, $urandom};
        init_regs[3] = 64'h11;
        init_regs[4] = 64'h99;
        init_regs[5] = 64'h22;
        for (int i = 0; i < 16; i++) reg_model[i] = init_regs[i];
        repeat (3) @(posedge clk);
        @(negedge clk);
        preload = 1'b0;
        rst = 1'b0;
        cyc = 0; free_at = 0; rd_done_at = -1; wr_done_at = -1;
        pa_cyc = -1; pb_cyc = -1; exp_valA = '0; exp_valB = '0;

        check("reset_rf_addr", 64'(rf_addr), 64'(NONREG));
        check("reset_valA", valA, 64'd0);
        step();

        read_tx(4'd3, 4'd5, 64'h11, 64'h22);
        read_tx(NONREG, 4'd4, 64'h0, 64'h99);
        read_tx(4'd4, NONREG, 64'h99, 64'h0);

        wr_tx(4'd2, 4'd7, 64'hAA, 64'hBB, 1'b1, 1'b1);
        read_tx(4'd2, 4'd7, 64'hAA, 64'hBB);
        wr_tx(4'd6, 4'd6, 64'h1, 64'h2, 1'b0, 1'b1);
        read_tx(4'd6, NONREG, 64'h2, 64'h0);
        wr_tx(NONREG, NONREG, 64'h5, 64'h6, 1'b0, 1'b0);

        // Simultaneous requests: write first, read accepted in the wr_done cycle.
        rd_valid = 1'b1; srcA = 4'd8; srcB = 4'd9;
        wr_valid = 1'b1; dstE = 4'd8; dstM = 4'd9; valE = 64'h55; valM = 64'h66;
        #1;
        check("both_rd_ready", 64'(rd_ready), 64'd0);
        check("both_wr_ready", 64'(wr_ready), 64'd1);
        wait_accept(2);
        wr_valid = 1'b0;
        step();
        step();
        check("wr_done_rd_ready", 64'(rd_ready), 64'd1);
        check("wr_done_pulse", 64'(wr_done), 64'd1);
        wait_accept(1);
        rd_valid = 1'b0;
        step(); step(); step();
        check("post_write_rd_done", 64'(rd_done), 64'd1);
        check("post_write_valA", valA, 64'h55);
        check("post_write_valB", valB, 64'h66);

        // Reset in RD_B: no rd_done, operands cleared.
        rd_valid = 1'b1; srcA = 4'd3; srcB = 4'd5;
        wait_accept(1);
        rd_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_rd_busy", 64'(busy), 64'd0);
        check("rst_rd_valA", valA, 64'd0);
        check("rst_rd_valB", valB, 64'd0);
        check("rst_rd_done", 64'(rd_done), 64'd0);
        step();
        check("rst_rd_no_done", 64'(rd_done), 64'd0);

        // Reset in WR_M: the E write and the in-flight M write both land.
        wr_valid = 1'b1; dstE = 4'd10; dstM = 4'd11; valE = 64'hA1; valM = 64'hB2;
        wait_accept(2);
        wr_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_wr_we", 64'(rf_we), 64'd0);
        check("rst_wr_done", 64'(wr_done), 64'd0);
        step();
        check("rst_wr_no_done", 64'(wr_done), 64'd0);
        read_tx(4'd10, 4'd11, 64'hA1, 64'hB2);

        // Random traffic, including mid-transaction resets.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            rd_valid = ($urandom_range(0, 2) != 0);
            wr_valid = ($urandom_range(0, 2) == 0);
            scramble_inputs();
            if ($urandom_range(0, 3) == 0) dstM = dstE;
            step();
        end
        rst = 1'b0; rd_valid = 1'b0; wr_valid = 1'b0;
        repeat (6) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
